// File: rtl/keypad_scanner_if.sv
// Keypad pin bundle plus the digit strobe toward the lock FSM.
// slave  = scanner side (senses columns, drives rows and the digit outputs)
// master = keypad/consumer side
interface keypad_scanner_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_out;
  logic       enter;
  logic       multi_key;

  modport master (output col_n, input row_n, key_out, enter, multi_key);
  modport slave  (input col_n, output row_n, key_out, enter, multi_key);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row scan, frame capture, press/release debounce,
// one enter strobe per physical press.
module keypad_scanner #(
  parameter int ROW_DWELL      = 4,  // >= 3 so the 2-flop column sync settles
  parameter int DEBOUNCE_SCANS = 3   // >= 1
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.slave   kp_if
);

  localparam int DW = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_EMIT, S_WAIT_REL} state_t;

  logic [3:0]    col_s1_q, col_s2_q;
  logic [DW-1:0] dwell_q;
  logic [1:0]    row_q;
  logic [15:0]   frame_q;
  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] stable_q, stable_d;
  logic [CW-1:0] rel_q, rel_d;
  logic [3:0]    key_out_q;
  logic          enter_q;
  logic          multi_q;

  logic          sample, frame_end;
  logic [15:0]   frame_full;
  logic [4:0]    bit_cnt;
  logic [3:0]    code_c;
  logic          is_none, is_single, is_multi;

  // Column synchronizer; idle lines read high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
    end else begin
      col_s1_q <= kp_if.col_n;
      col_s2_q <= col_s1_q;
    end
  end

  assign sample    = (dwell_q == DW'(ROW_DWELL - 1));
  assign frame_end = sample && (row_q == 2'd3);

  // Row/dwell sequencer and per-row frame capture; runs in every FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q <= '0;
      row_q   <= 2'd0;
      frame_q <= '0;
    end else if (sample) begin
      dwell_q <= '0;
      row_q   <= row_q + 2'd1;
      frame_q[{row_q, 2'b00} +: 4] <= ~col_s2_q;
    end else begin
      dwell_q <= dwell_q + DW'(1);
    end
  end

  // Classify the complete frame; row 3 is taken live since it is sampled now.
  always_comb begin
    frame_full        = frame_q;
    frame_full[15:12] = ~col_s2_q;
    bit_cnt           = '0;
    code_c            = '0;
    for (int i = 0; i < 16; i++) begin
      bit_cnt = bit_cnt + 5'(frame_full[i]);
      if (frame_full[i]) code_c = 4'(i);
    end
    is_none   = (bit_cnt == 5'd0);
    is_single = (bit_cnt == 5'd1);
    is_multi  = (bit_cnt >= 5'd2);
  end

  // FSM state and debounce counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_SCAN;
      cand_q   <= '0;
      stable_q <= '0;
      rel_q    <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      rel_q    <= rel_d;
    end
  end

  // Next-state: counters only move on frame ends; EMIT is a single cycle.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    rel_d    = rel_q;
    case (state_q)
      S_SCAN: begin
        if (frame_end && is_single) begin
          cand_d   = code_c;
          stable_d = CW'(1);
          state_d  = (DEBOUNCE_SCANS == 1) ? S_EMIT : S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (frame_end) begin
          if (is_single && (code_c == cand_q)) begin
            if (int'(stable_q) < DEBOUNCE_SCANS) stable_d = stable_q + CW'(1);
            if (int'(stable_q) + 1 >= DEBOUNCE_SCANS) state_d = S_EMIT;
          end else begin
            stable_d = '0;
            state_d  = S_SCAN;
          end
        end
      end
      S_EMIT: begin
        rel_d   = '0;
        state_d = S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (frame_end) begin
          if (is_none) begin
            if (int'(rel_q) < DEBOUNCE_SCANS) rel_d = rel_q + CW'(1);
            if (int'(rel_q) + 1 >= DEBOUNCE_SCANS) state_d = S_SCAN;
          end else begin
            rel_d = '0;
          end
        end
      end
      default: state_d = S_SCAN;
    endcase
  end

  // Registered outputs: strobe and code line up with the EMIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_out_q <= 4'h0;
      enter_q   <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      enter_q <= (state_d == S_EMIT);
      if (state_d == S_EMIT) key_out_q <= cand_d;
      if (frame_end) multi_q <= is_multi;
    end
  end

  assign kp_if.row_n     = ~(4'b0001 << row_q);
  assign kp_if.key_out   = key_out_q;
  assign kp_if.enter     = enter_q;
  assign kp_if.multi_key = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed frame table, reset corner sequences and
// randomized key patterns against a frame-level acceptance model.
module tb_keypad_scanner;
  localparam int D     = 3;
  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0;
  int          n_chk = 0;
  int          n_pass = 0;

  keypad_scanner_if kp_if();

  keypad_scanner #(.ROW_DWELL(4), .DEBOUNCE_SCANS(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .kp_if (kp_if)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    kp_if.col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!kp_if.row_n[r])
        for (int c = 0; c < 4; c++)
          if (keys[4*r+c]) kp_if.col_n[c] = 1'b0;
  end

  typedef struct {
    logic [15:0] keys;
    logic        en;
    logic [3:0]  key;
    logic        multi;
  } vec_t;

  vec_t tbl[36];

  // Frame-level acceptance model
  bit       m_armed;
  int       m_quiet, m_streak;
  logic [3:0] m_code, m_key;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    m_armed = 1; m_quiet = 0; m_streak = 0; m_code = 0; m_key = 0;
  endtask

  task automatic model_frame(input logic [15:0] ks, output logic en,
                             output logic [3:0] k, output logic multi);
    int n; logic [3:0] code;
    n = 0; code = 0;
    for (int i = 0; i < 16; i++) if (ks[i]) begin n++; code = 4'(i); end
    en = 0; multi = (n >= 2);
    if (!m_armed) begin
      m_quiet = (n == 0) ? m_quiet + 1 : 0;
      if (m_quiet == D) begin m_armed = 1; m_streak = 0; end
    end else if (m_streak == 0) begin
      if (n == 1) begin m_streak = 1; m_code = code; end
    end else begin
      if (n == 1 && code == m_code) m_streak++;
      else m_streak = 0;
    end
    if (m_armed && m_streak == D) begin
      en = 1; m_key = m_code; m_armed = 0; m_quiet = 0; m_streak = 0;
    end
    k = m_key;
  endtask

  // One full frame from the first clock after a frame boundary.
  task automatic run_frame(input logic [15:0] ks, input logic en,
                           input logic [3:0] k, input logic multi);
    int stray, rowbad;
    logic [3:0] rexp;
    keys = ks; stray = 0; rowbad = 0;
    for (int c = 1; c <= FRAME; c++) begin
      step();
      rexp = ~(4'b0001 << ((c % FRAME) / 4));
      if (kp_if.row_n !== rexp) rowbad++;
      if (c < FRAME && kp_if.enter !== 1'b0) stray++;
    end
    chk("row_seq", rowbad, 0);
    chk("stray_enter", stray, 0);
    chk("enter", int'(kp_if.enter), int'(en));
    chk("key_out", int'(kp_if.key_out), int'(k));
    chk("multi_key", int'(kp_if.multi_key), int'(multi));
  endtask

  task automatic run_cycles(input int n);
    int stray;
    stray = 0;
    for (int c = 0; c < n; c++) begin
      step();
      if (kp_if.enter !== 1'b0) stray++;
    end
    chk("partial_enter", stray, 0);
  endtask

  // Asynchronous reset with output checks, released just after an edge.
  task automatic do_reset();
    rst = 1'b1; #1;
    chk("rst_row_n", int'(kp_if.row_n), 'hE);
    chk("rst_key_out", int'(kp_if.key_out), 0);
    chk("rst_enter", int'(kp_if.enter), 0);
    chk("rst_multi", int'(kp_if.multi_key), 0);
    step(); step();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic en, mu; logic [3:0] k;
    logic [15:0] ks;
    int hold;

    tbl[0]  = '{16'h0200, 1'b0, 4'h0, 1'b0};
    tbl[1]  = '{16'h0200, 1'b0, 4'h0, 1'b0};
    tbl[2]  = '{16'h0200, 1'b1, 4'h9, 1'b0};
    tbl[3]  = '{16'h0200, 1'b0, 4'h9, 1'b0};
    tbl[4]  = '{16'h0200, 1'b0, 4'h9, 1'b0};
    tbl[5]  = '{16'h0200, 1'b0, 4'h9, 1'b0};
    tbl[6]  = '{16'h0000, 1'b0, 4'h9, 1'b0};
    tbl[7]  = '{16'h0000, 1'b0, 4'h9, 1'b0};
    tbl[8]  = '{16'h0000, 1'b0, 4'h9, 1'b0};
    tbl[9]  = '{16'h0080, 1'b0, 4'h9, 1'b0};
    tbl[10] = '{16'h0000, 1'b0, 4'h9, 1'b0};
    tbl[11] = '{16'h0080, 1'b0, 4'h9, 1'b0};
    tbl[12] = '{16'h0000, 1'b0, 4'h9, 1'b0};
    tbl[13] = '{16'h8001, 1'b0, 4'h9, 1'b1};
    tbl[14] = '{16'h8001, 1'b0, 4'h9, 1'b1};
    tbl[15] = '{16'h0001, 1'b0, 4'h9, 1'b0};
    tbl[16] = '{16'h0001, 1'b0, 4'h9, 1'b0};
    tbl[17] = '{16'h0001, 1'b1, 4'h0, 1'b0};
    tbl[18] = '{16'h0000, 1'b0, 4'h0, 1'b0};
    tbl[19] = '{16'h0000, 1'b0, 4'h0, 1'b0};
    tbl[20] = '{16'h0000, 1'b0, 4'h0, 1'b0};
    tbl[21] = '{16'h0020, 1'b0, 4'h0, 1'b0};
    tbl[22] = '{16'h0020, 1'b0, 4'h0, 1'b0};
    tbl[23] = '{16'h0020, 1'b1, 4'h5, 1'b0};
    tbl[24] = '{16'h0000, 1'b0, 4'h5, 1'b0};
    tbl[25] = '{16'h0000, 1'b0, 4'h5, 1'b0};
    tbl[26] = '{16'h0020, 1'b0, 4'h5, 1'b0};
    tbl[27] = '{16'h0020, 1'b0, 4'h5, 1'b0};
    tbl[28] = '{16'h0020, 1'b0, 4'h5, 1'b0};
    tbl[29] = '{16'h0000, 1'b0, 4'h5, 1'b0};
    tbl[30] = '{16'h0000, 1'b0, 4'h5, 1'b0};
    tbl[31] = '{16'h0000, 1'b0, 4'h5, 1'b0};
    tbl[32] = '{16'h0020, 1'b0, 4'h5, 1'b0};
    tbl[33] = '{16'h0020, 1'b0, 4'h5, 1'b0};
    tbl[34] = '{16'h0020, 1'b1, 4'h5, 1'b0};
    tbl[35] = '{16'h0000, 1'b0, 4'h5, 1'b0};

    // Power-on reset
    #2;
    do_reset();

    // Directed frames: single press, bounce, multi-key, release debounce
    for (int i = 0; i < 36; i++)
      run_frame(tbl[i].keys, tbl[i].en, tbl[i].key, tbl[i].multi);

    // Reset mid-scan while a key is held: outputs clear, scan restarts at row 0
    keys = 16'h0020;
    run_cycles(5);
    do_reset();
    keys = 16'h0000;
    run_frame(16'h0000, 1'b0, 4'h0, 1'b0);

    // Reset while debouncing key A: no strobe, re-accepted 3 frames later
    run_frame(16'h0400, 1'b0, 4'h0, 1'b0);
    run_frame(16'h0400, 1'b0, 4'h0, 1'b0);
    run_cycles(7);
    do_reset();
    run_frame(16'h0400, 1'b0, 4'h0, 1'b0);
    run_frame(16'h0400, 1'b0, 4'h0, 1'b0);
    run_frame(16'h0400, 1'b1, 4'hA, 1'b0);
    run_frame(16'h0400, 1'b0, 4'hA, 1'b0);

    // Randomized key patterns held for 1..4 frames
    do_reset();
    for (int f = 0; f < 80; ) begin
      case ($urandom_range(0, 5))
        0, 1:    ks = 16'h0000;
        2, 3, 4: begin
          case ($urandom_range(0, 2))
            0:       ks = 16'h0008;
            1:       ks = 16'h0040;
            default: ks = 16'h1000;
          endcase
        end
        default: ks = (16'h0001 << $urandom_range(0, 7)) | (16'h0100 << $urandom_range(0, 7));
      endcase
      hold = int'($urandom_range(1, 4));
      for (int h = 0; h < hold; h++) begin
        model_frame(ks, en, k, mu);
        run_frame(ks, en, k, mu);
        f++;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
